// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides CLK to a pixel enable and walks the
// horizontal/vertical counters, emitting registered sync, blank and strobes.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10,
  parameter int   FCW      = 8
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           EN,
  output logic           pix_ce,
  output logic           HS,
  output logic           VS,
  output logic           blank,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DC_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HC_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VC_LAST = CW'(V_TOTAL - 1);

  logic [DW-1:0]  dc_q, dc_d;
  logic [CW-1:0]  hc_q, hc_d;
  logic [CW-1:0]  vc_q, vc_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic           pix_ce_q, pix_ce_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           blank_q, blank_d;
  logic           ls_q, ls_d;
  logic           fs_q, fs_d;
  logic           tick, h_wrap, v_wrap;

  always_comb begin
    tick   = EN && (dc_q == DC_LAST);
    h_wrap = (hc_q == HC_LAST);
    v_wrap = (vc_q == VC_LAST);

    dc_d = dc_q;
    hc_d = hc_q;
    vc_d = vc_q;
    fc_d = fc_q;

    if (EN) dc_d = tick ? '0 : dc_q + DW'(1);

    if (tick) begin
      if (h_wrap) begin
        hc_d = '0;
        if (v_wrap) begin
          vc_d = '0;
          fc_d = fc_q + FCW'(1);
        end else begin
          vc_d = vc_q + CW'(1);
        end
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end

    // Decodes look at the next-state counters so they land with x/y.
    pix_ce_d = tick;
    ls_d     = tick && h_wrap;
    fs_d     = ls_d && v_wrap;
    blank_d  = (hc_d >= CW'(H_ACTIVE)) || (vc_d >= CW'(V_ACTIVE));
    hs_d     = ((hc_d >= CW'(HS_BEG)) && (hc_d < CW'(HS_END))) ? HS_POL : ~HS_POL;
    vs_d     = ((vc_d >= CW'(VS_BEG)) && (vc_d < CW'(VS_END))) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dc_q     <= '0;
      hc_q     <= '0;
      vc_q     <= '0;
      fc_q     <= '0;
      pix_ce_q <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      blank_q  <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      dc_q     <= dc_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      fc_q     <= fc_d;
      pix_ce_q <= pix_ce_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign blank       = blank_q;
  assign x           = hc_q;
  assign y           = vc_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-timing instances compared each cycle
// against a pixel-count model, plus directed period/freeze/reset checks.
module tb_vga_timing_gen;

  localparam int DA = 3, AHA = 8, AHF = 2, AHS = 3, AHB = 2;
  localparam int AVA = 4, AVF = 1, AVS = 2, AVB = 1, AFCW = 3;
  localparam int AHT = AHA + AHF + AHS + AHB;
  localparam int AVT = AVA + AVF + AVS + AVB;
  localparam int DB = 1, BHA = 6, BHF = 1, BHS = 2, BHB = 1;
  localparam int BVA = 3, BVF = 1, BVS = 1, BVB = 1, BFCW = 4;
  localparam int BHT = BHA + BHF + BHS + BHB;
  localparam int BVT = BVA + BVF + BVS + BVB;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;

  logic a_pce, a_hs, a_vs, a_blank, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [AFCW-1:0] a_fc;
  logic b_pce, b_hs, b_vs, b_blank, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [BFCW-1:0] b_fc;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(
    .CLK_DIV(DA), .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(10), .FCW(AFCW)
  ) u_a (
    .CLK(clk), .RST_N(rst_n), .EN(en), .pix_ce(a_pce), .HS(a_hs), .VS(a_vs),
    .blank(a_blank), .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs),
    .frame_count(a_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(DB), .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(10), .FCW(BFCW)
  ) u_b (
    .CLK(clk), .RST_N(rst_n), .EN(en), .pix_ce(b_pce), .HS(b_hs), .VS(b_vs),
    .blank(b_blank), .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs),
    .frame_count(b_fc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: everything follows from the number of enabled edges since reset.
  int n = 0;
  bit pce_a = 0, pce_b = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 0; pce_a <= 0; pce_b <= 0;
    end else if (en) begin
      n <= n + 1; pce_a <= ((n + 1) % DA) == 0; pce_b <= ((n + 1) % DB) == 0;
    end else begin
      pce_a <= 0; pce_b <= 0;
    end
  end

  function automatic logic [63:0] expv(input int cnt, input bit pce, input int d,
      input int ha, input int hf, input int hsn, input int hb,
      input int va, input int vf, input int vsn, input int vb,
      input bit hp, input bit vp, input int fcw);
    int ht, vt, t, p, hc, vc, fc;
    bit hs, vs, bl, ls, fs;
    ht = ha + hf + hsn + hb;
    vt = va + vf + vsn + vb;
    t  = cnt / d;
    p  = t % (ht * vt);
    hc = p % ht;
    vc = p / ht;
    fc = (t / (ht * vt)) % (1 << fcw);
    hs = (hc >= ha + hf && hc < ha + hf + hsn) ? hp : !hp;
    vs = (vc >= va + vf && vc < va + vf + vsn) ? vp : !vp;
    bl = (hc >= ha) || (vc >= va);
    ls = pce && (hc == 0);
    fs = pce && (p == 0);
    return {30'b0, pce, hs, vs, bl, ls, fs, 8'(fc), 10'(hc), 10'(vc)};
  endfunction

  function automatic logic [63:0] exp_a(input int cnt, input bit pce);
    return expv(cnt, pce, DA, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, 1'b0, 1'b0, AFCW);
  endfunction
  function automatic logic [63:0] exp_b(input int cnt, input bit pce);
    return expv(cnt, pce, DB, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b1, 1'b1, BFCW);
  endfunction

  logic [63:0] obs_a, obs_b;
  assign obs_a = {30'b0, a_pce, a_hs, a_vs, a_blank, a_ls, a_fs, 8'(a_fc), a_x, a_y};
  assign obs_b = {30'b0, b_pce, b_hs, b_vs, b_blank, b_ls, b_fs, 8'(b_fc), b_x, b_y};

  always @(negedge clk) begin
    chk("a_state", obs_a, exp_a(n, pce_a));
    chk("b_state", obs_b, exp_b(n, pce_b));
  end

  int tx, ty;
  function automatic bit cond(input int which);
    case (which)
      0: return a_ls;
      1: return a_fs;
      2: return b_fs;
      default: return (int'(a_x) == tx) && (int'(a_y) == ty);
    endcase
  endfunction

  task automatic wait_until(input string tag, input int which, input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (cond(which)) begin ok = 1; break; end
    end
    chk({"wait_", tag}, 64'(ok), 64'd1);
  endtask

  task automatic cyc(input bit e);
    @(posedge clk); #2 en = e;
  endtask

  task automatic release_and_check();
    int fa = 0, fb = 0;
    @(posedge clk); #2 rst_n = 1'b1; en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (a_pce && fa == 0) fa = k;
      if (b_pce && fb == 0) fb = k;
    end
    chk("first_pce_a", 64'(fa), 64'(DA));
    chk("first_pce_b", 64'(fb), 64'(DB));
  endtask

  task automatic async_reset_now();
    rst_n = 1'b0;
    #1;
    chk("arst_a", obs_a, exp_a(0, 1'b0));
    chk("arst_b", obs_b, exp_b(0, 1'b0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, hsc, vsc, pc, rem, first;
    logic [63:0] snap_a, snap_b;
    logic [9:0] xt;

    #1 rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", obs_a, {30'b0, 6'b011000, 8'd0, 10'd0, 10'd0});
    chk("rst_b", obs_b, {30'b0, 6'b000000, 8'd0, 10'd0, 10'd0});
    release_and_check();

    // Line period and HS width on A.
    wait_until("a_ls", 0, AHT * DA + 5);
    cnt = 0; hsc = 0;
    for (int i = 0; i < 2 * AHT * DA; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (a_hs == 1'b0) hsc++;
      if (a_ls) break;
    end
    chk("a_line_per", 64'(cnt), 64'(AHT * DA));
    chk("a_hs_cyc", 64'(hsc), 64'(AHS * DA));

    // Frame period and VS width on A.
    wait_until("a_fs", 1, AHT * AVT * DA + 5);
    cnt = 0; vsc = 0;
    for (int i = 0; i < 2 * AHT * AVT * DA; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (a_vs == 1'b0) vsc++;
      if (a_fs) break;
    end
    chk("a_frame_per", 64'(cnt), 64'(AHT * AVT * DA));
    chk("a_vs_cyc", 64'(vsc), 64'(AVS * AHT * DA));

    // Corner instance: divide-by-1, active-high syncs.
    wait_until("b_fs", 2, BHT * BVT + 5);
    cnt = 0; hsc = 0; pc = 0;
    for (int i = 0; i < 2 * BHT * BVT; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (b_hs == 1'b1) hsc++;
      if (b_pce) pc++;
      if (b_fs) break;
    end
    chk("b_frame_per", 64'(cnt), 64'(BHT * BVT));
    chk("b_pce_cnt", 64'(pc), 64'(BHT * BVT));
    chk("b_hs_cyc", 64'(hsc), 64'(BHS * BVT));

    // Random enable gaps; long enough for A's frame counter to wrap.
    for (int i = 0; i < 4000; i++) cyc($urandom_range(0, 7) != 0);
    cyc(1'b1);

    // Freeze mid-line.
    tx = 3; ty = 2;
    wait_until("a_pos_frz", 3, 2 * AHT * AVT * DA);
    #1 en = 1'b0;
    snap_a = {a_hs, a_vs, a_blank, 29'(a_fc), a_x, a_y};
    snap_b = {b_hs, b_vs, b_blank, 29'(b_fc), b_x, b_y};
    rem = DA - (n % DA);
    xt = a_x;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk("frz_a", {a_hs, a_vs, a_blank, 29'(a_fc), a_x, a_y}, snap_a);
      chk("frz_b", {b_hs, b_vs, b_blank, 29'(b_fc), b_x, b_y}, snap_b);
      chk("frz_strb", {a_pce, a_ls, a_fs, b_pce, b_ls, b_fs}, 64'd0);
    end
    #1 en = 1'b1;
    first = 0;
    for (int k = 1; k <= DA + 1; k++) begin
      @(posedge clk); #1;
      if (a_pce && first == 0) begin first = k; chk("resume_x", a_x, xt + 10'd1); end
    end
    chk("resume_tick", 64'(first), 64'(rem));

    // Asynchronous reset inside both sync regions.
    tx = AHA + AHF + 1; ty = AVA + AVF + 1;
    wait_until("a_pos_sync", 3, 2 * AHT * AVT * DA);
    chk("in_sync", {a_hs, a_vs}, 2'b00);
    @(negedge clk); #2;
    async_reset_now();
    repeat (2) @(posedge clk);
    release_and_check();

    // Random async resets at arbitrary phases.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'($urandom_range(50, 400)); i++) cyc($urandom_range(0, 5) != 0);
      @(posedge clk); #($urandom_range(1, 3));
      async_reset_now();
      repeat (2) @(posedge clk);
      release_and_check();
    end
    for (int i = 0; i < 300; i++) cyc($urandom_range(0, 3) != 0);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
